// File: rtl/fifo_fwd_n.sv
// fifo_fwd_n: first-word fall-through FIFO with optional zero-latency bypass
// when empty. Occupancy, full and almost-full flags are decoded from the
// registered count only, so a same-cycle pop never frees space for a push.
module fifo_fwd_n #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 3,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         if_full_n,
  input  logic                         if_write_ce,
  input  logic                         if_write,
  input  logic [DATA_WIDTH-1:0]        if_din,
  output logic                         if_empty_n,
  input  logic                         if_read_ce,
  input  logic                         if_read,
  output logic [DATA_WIDTH-1:0]        if_dout,
  output logic                         if_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   if_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;

  logic wr_req;
  logic rd_req;
  logic wr;
  logic rd;
  logic is_empty;
  logic pass_thru;

  // Pointer increment that wraps explicitly, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign wr_req   = if_write && if_write_ce;
  assign rd_req   = if_read && if_read_ce;
  assign is_empty = (count == '0);

  assign if_full_n      = (count < DEPTH_C);
  assign if_almost_full = (count >= AF_C);
  assign if_count       = count;

  // Head-of-queue view: stored head when occupied, otherwise the bypassed
  // write data (BYPASS=1) or nothing valid (BYPASS=0).
  always_comb begin
    if_empty_n = 1'b0;
    if_dout    = mem[rptr];
    if (!is_empty) begin
      if_empty_n = 1'b1;
    end else if (BYPASS != 0) begin
      if_empty_n = wr_req;
      if_dout    = if_din;
    end
  end

  assign wr = wr_req && if_full_n;
  assign rd = rd_req && if_empty_n;

  // An empty FIFO that is written and read in the same cycle hands the word
  // straight through; nothing is stored.
  assign pass_thru = (BYPASS != 0) && is_empty && wr && rd;

  // Pointer and occupancy state; cleared asynchronously, storage is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (!pass_thru) begin
      if (wr) wptr <= ptr_inc(wptr);
      if (rd) rptr <= ptr_inc(rptr);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write; left unreset so it maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr && !pass_thru) mem[wptr] <= if_din;
  end

endmodule

// File: tb/tb_fifo_fwd_n.sv
// Randomised plus directed bench for fifo_fwd_n. Two instances share the
// stimulus: one with bypass, one without; each is compared against a
// queue-based reference model.
module tb_fifo_fwd_n;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int AF    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          w, wce, r, rce;
  logic [DW-1:0] din;

  logic          full_n1, empty_n1, af1;
  logic [DW-1:0] dout1;
  logic [CW-1:0] cnt1;
  logic          full_n0, empty_n0, af0;
  logic [DW-1:0] dout0;
  logic [CW-1:0] cnt0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_fwd_n #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .BYPASS(1)) u_dut_bp (
    .clk(clk), .reset(reset),
    .if_full_n(full_n1), .if_write_ce(wce), .if_write(w), .if_din(din),
    .if_empty_n(empty_n1), .if_read_ce(rce), .if_read(r), .if_dout(dout1),
    .if_almost_full(af1), .if_count(cnt1)
  );

  fifo_fwd_n #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset),
    .if_full_n(full_n0), .if_write_ce(wce), .if_write(w), .if_din(din),
    .if_empty_n(empty_n0), .if_read_ce(rce), .if_read(r), .if_dout(dout0),
    .if_almost_full(af0), .if_count(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare one instance's outputs with what its queue says they must be.
  task automatic check_outputs(input string tag, input bit bp, input int size,
                               input logic [DW-1:0] head, input logic fn,
                               input logic en, input logic [DW-1:0] dout,
                               input logic af, input logic [CW-1:0] cnt);
    bit exp_en;
    exp_en = (size > 0) || (bp && w && wce);
    chk({tag, "/full_n"},  32'(fn),  32'(size < DEPTH));
    chk({tag, "/empty_n"}, 32'(en),  32'(exp_en));
    if (exp_en) chk({tag, "/dout"}, 32'(dout), 32'((size > 0) ? head : din));
    chk({tag, "/almost_full"}, 32'(af), 32'(size >= AF));
    chk({tag, "/count"}, 32'(cnt), size);
  endtask

  task automatic check_both(input string tag);
    logic [DW-1:0] h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    check_outputs({tag, "/bp"}, 1'b1, q1.size(), h1, full_n1, empty_n1, dout1, af1, cnt1);
    check_outputs({tag, "/nb"}, 1'b0, q0.size(), h0, full_n0, empty_n0, dout0, af0, cnt0);
  endtask

  // One cycle: drive inputs just after an edge, check mid-cycle, then apply
  // the FIFO rules to both models at the edge.
  task automatic step(input logic iw, input logic iwce, input logic [DW-1:0] id,
                      input logic ir, input logic irce);
    bit wreq, rreq, wr1, rd1, wr0, rd0, pass1;
    int s1, s0;
    w = iw; wce = iwce; din = id; r = ir; rce = irce;
    #3;
    check_both("step");
    wreq  = iw && iwce;
    rreq  = ir && irce;
    s1    = q1.size();
    s0    = q0.size();
    wr1   = wreq && (s1 < DEPTH);
    rd1   = rreq && ((s1 > 0) || wreq);
    pass1 = (s1 == 0) && wr1 && rd1;
    wr0   = wreq && (s0 < DEPTH);
    rd0   = rreq && (s0 > 0);
    @(posedge clk);
    if (!pass1) begin
      if (rd1) void'(q1.pop_front());
      if (wr1) q1.push_back(id);
    end
    if (rd0) void'(q0.pop_front());
    if (wr0) q0.push_back(id);
    #1;
  endtask

  // Pull reset low between edges and check it acts before any clock edge.
  task automatic async_reset();
    w = 1'b0; wce = 1'b0; r = 1'b0; rce = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    q1.delete();
    q0.delete();
    chk("arst/count_bp", 32'(cnt1), 0);
    chk("arst/count_nb", 32'(cnt0), 0);
    chk("arst/empty_n_bp", 32'(empty_n1), 0);
    chk("arst/full_n_nb", 32'(full_n0), 1);
    check_both("arst");
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    w = 1'b0; wce = 1'b0; r = 1'b0; rce = 1'b0; din = '0;
    #2;
    check_both("reset");
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Bypass: first edge after reset release, write 0xA5 and read together.
    w = 1'b1; wce = 1'b1; din = 8'hA5; r = 1'b1; rce = 1'b1;
    #1;
    chk("bypass/empty_n", 32'(empty_n1), 1);
    chk("bypass/dout", 32'(dout1), 32'h0A5);
    step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    chk("bypass/count_held", 32'(cnt1), 0);
    chk("nobypass/count", 32'(cnt0), 1);
    async_reset();

    // Fill past full, then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill/full_n", 32'(full_n1), 0);
    chk("fill/count", 32'(cnt1), 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("drain/empty_n", 32'(empty_n0), 0);

    // Wrap: hold occupancy at one while streaming.
    async_reset();
    step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b1);
    chk("wrap/count", 32'(cnt1), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Full plus read: the write is refused.
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("fullrd/count", 32'(cnt1), 2);
    chk("fullrd/head", 32'(dout1), 32'h31);

    // Clock-enable gating.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    chk("ce/count", 32'(cnt0), 2);

    // Reset mid-operation, then non-bypass latency of a fresh write.
    async_reset();
    step(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    chk("lat/empty_n_nb", 32'(empty_n0), 1);
    chk("lat/dout_nb", 32'(dout0), 32'h7E);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) async_reset();
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) < 8), 8'($urandom),
           1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 9) < 8));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_fwd_n.md
FIFO_FWD_N -- requirements
Module: fifo_fwd_n

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning payload width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning storage entries (>=2; non-power-of-two legal).
REQ-003 The block SHALL have parameter AF_THRESH, default 3, meaning almost-full occupancy threshold (1..DEPTH).
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 = zero-latency write-to-read fall-through when empty, 0 = one-cycle latency.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning reset; one clock, reset asynchronous active-low.
REQ-007 The block SHALL have port if_full_n, output, 1, meaning the FIFO can accept a write.
REQ-008 The block SHALL have port if_write_ce, input, 1, meaning the write clock-enable.
REQ-009 The block SHALL have port if_write, input, 1, meaning the write request.
REQ-010 The block SHALL have port if_din, input, DATA_WIDTH, meaning the write data.
REQ-011 The block SHALL have port if_empty_n, output, 1, meaning if_dout is valid.
REQ-012 The block SHALL have port if_read_ce, input, 1, meaning the read clock-enable.
REQ-013 The block SHALL have port if_read, input, 1, meaning the read/pop request.
REQ-014 The block SHALL have port if_dout, output, DATA_WIDTH, meaning the head-of-queue data (first-word fall-through).
REQ-015 The block SHALL have port if_almost_full, output, 1, meaning count >= AF_THRESH.
REQ-016 The block SHALL have port if_count, output, clog2(DEPTH+1), meaning current stored occupancy.

Function
REQ-017 Write accept wr SHALL be if_write && if_write_ce && if_full_n; a write while full SHALL be dropped with no state change.
REQ-018 Read accept rd SHALL be if_read && if_read_ce && if_empty_n; a read while empty SHALL be ignored.
REQ-019 if_full_n SHALL be (count < DEPTH), decoded from registered count only; a same-cycle read SHALL NOT free space for a write.
REQ-020 When count > 0, if_empty_n SHALL be 1 and if_dout SHALL equal mem[rptr] combinationally.
REQ-021 When count == 0 and BYPASS=1, if_empty_n SHALL equal (if_write && if_write_ce) and if_dout SHALL equal if_din.
REQ-022 When count == 0 and BYPASS=0, if_empty_n SHALL be 0; written data SHALL appear at if_dout the next cycle.
REQ-023 Bypass pass-through, when count==0, BYPASS=1, wr and rd are all true, SHALL leave count, pointers and memory unchanged.
REQ-024 Otherwise, each edge: wr stores if_din at mem[wptr] and advances wptr; rd advances rptr; count += wr - rd.
REQ-025 wptr and rptr SHALL wrap from DEPTH-1 to 0, correct for non-power-of-two DEPTH.
REQ-026 Simultaneous wr and rd with 0 < count < DEPTH SHALL keep count constant and preserve FIFO order.
REQ-027 if_almost_full and if_count SHALL be registered-state decodes with no combinational path from inputs.
REQ-028 Data ordering SHALL be strict FIFO; no entry SHALL be duplicated or lost across wrap-around.

Reset
REQ-029 Asserting reset (low) SHALL immediately, without clk, set count=0, wptr=0, rptr=0.
REQ-030 During and after reset, outputs SHALL be if_full_n=1, if_almost_full=0, if_count=0, if_empty_n=0 unless bypass write present (REQ-021).
REQ-031 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all stored entries.
REQ-032 Deassertion SHALL be synchronised by the integrator; the block SHALL accept writes on the first clk edge after deassertion.

Verification (DATA_WIDTH=8, DEPTH=3, AF_THRESH=2 unless noted)
REQ-033 Bypass: empty, BYPASS=1, write 0xA5 with read same cycle -> if_empty_n=1, if_dout=0xA5 that cycle, if_count stays 0.
REQ-034 Fill/overflow: write 0x01,0x02,0x03,0x04 with no reads -> if_almost_full=1 at count 2, if_full_n=0 at count 3, 0x04 dropped; reads return 0x01,0x02,0x03 then if_empty_n=0.
REQ-035 Wrap: 10 cycles of simultaneous write/read with count held at 1, data 0x10..0x19 -> outputs in order, pointers wrap past 2, count stays 1.
REQ-036 Full + read: count=3, write 0x55 and read same cycle -> head popped, 0x55 rejected, count=2.
REQ-037 CE gating: if_write=1, if_write_ce=0 and if_read=1, if_read_ce=0 for 5 cycles -> no state change.
REQ-038 Async reset: count=2, pull reset low between edges -> if_count=0, if_empty_n=0, if_full_n=1 before next edge; BYPASS=0 write 0x7E then shows if_dout=0x7E one cycle later.
